// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module : reg_write_arbiter
// Brief  : Round-robin arbiter sharing the register-file write port among
//          N_REQ writeback sources, with a registered write stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_write_arbiter #(
  parameter int N_REQ       = 3,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [5*N_REQ-1:0]    req_addr,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic                  write,
  output logic [4:0]            writeaddress,
  output logic [31:0]           dinreg,
  output logic [2:0]            grant_id,
  output logic [31:0]           pending_mask
);

  logic        r_write;
  logic [4:0]  r_waddr;
  logic [31:0] r_din;
  logic [2:0]  r_gid;
  logic [2:0]  r_rr_ptr;

  logic             w_found;
  logic [2:0]       w_gnt;
  logic [3:0]       w_sum;
  logic [N_REQ-1:0] w_ready;
  logic [4:0]       w_sel_addr;
  logic [31:0]      w_sel_data;
  logic             w_accept;
  logic [2:0]       w_next_ptr;

  // Search upward from the round-robin pointer, wrapping at N_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(k);
      if (w_sum >= 4'(N_REQ)) begin
        w_sum = w_sum - 4'(N_REQ);
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (!w_found && (w_sum == 4'(j)) && req_valid[j]) begin
          w_found = 1'b1;
          w_gnt   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    w_ready    = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ready[i] = w_found && !hold && !rst && (w_gnt == 3'(i));
      if (w_gnt == 3'(i)) begin
        w_sel_addr = req_addr[5*i +: 5];
        w_sel_data = req_data[32*i +: 32];
      end
    end
  end

  assign w_accept   = |w_ready;
  assign w_next_ptr = (w_gnt == 3'(N_REQ-1)) ? 3'd0 : (w_gnt + 3'd1);

  // Writes to r0 are consumed (pointer still advances) but never drive the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_waddr  <= '0;
      r_din    <= '0;
      r_gid    <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_write  <= !(ZERO_REG_RO && (w_sel_addr == 5'd0));
      r_waddr  <= w_sel_addr;
      r_din    <= w_sel_data;
      r_gid    <= w_gnt;
      r_rr_ptr <= w_next_ptr;
    end else begin
      r_write  <= 1'b0;
    end
  end

  assign req_ready    = w_ready;
  assign write        = r_write;
  assign writeaddress = r_waddr;
  assign dinreg       = r_din;
  assign grant_id     = r_gid;
  assign pending_mask = r_write ? (32'd1 << r_waddr) : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module : tb_reg_write_arbiter
// Brief  : Vector-table and scoreboard bench for reg_write_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

  localparam int N = 3;

  logic           clk;
  logic           rst;
  logic           hold;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [5*N-1:0] req_addr;
  logic [32*N-1:0] req_data;
  logic           write;
  logic [4:0]     writeaddress;
  logic [31:0]    dinreg;
  logic [2:0]     grant_id;
  logic [31:0]    pending_mask;

  reg_write_arbiter #(.N_REQ(N), .ZERO_REG_RO(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .write        (write),
    .writeaddress (writeaddress),
    .dinreg       (dinreg),
    .grant_id     (grant_id),
    .pending_mask (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model fed by the write port.
  logic [31:0] rf [32];
  logic        zero_written;
  initial zero_written = 1'b0;
  always @(posedge clk) begin
    if (write) begin
      rf[writeaddress] <= dinreg;
      if (writeaddress == 5'd0) zero_written <= 1'b1;
    end
  end

  typedef struct {
    logic        rst;
    logic        hold;
    logic [2:0]  valid;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [2:0]  ready;
  } vec_t;

  typedef struct {
    logic        write;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  gid;
  } exp_t;

  localparam int NV = 25;
  vec_t tbl [NV];
  exp_t sb [$];

  int tests;
  int failed;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  logic [4:0]  a_req [N];
  logic [31:0] d_req [N];
  exp_t        cur;
  exp_t        got;
  int          g;
  logic [2:0]  seen;

  initial begin
    tests  = 0;
    failed = 0;
    rst = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    cur = '{1'b0, 5'd0, 32'd0, 3'd0};

    //          rst   hold  valid   a0     d0      ready
    tbl[0]  = '{1'b1, 1'b0, 3'b111, 5'd3, 32'd100, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 3'b111, 5'd3, 32'd100, 3'b000};
    tbl[2]  = '{1'b0, 1'b0, 3'b010, 5'd3, 32'd100, 3'b010};
    tbl[3]  = '{1'b0, 1'b0, 3'b000, 5'd3, 32'd100, 3'b000};
    tbl[4]  = '{1'b1, 1'b0, 3'b111, 5'd3, 32'd100, 3'b000};
    tbl[5]  = '{1'b0, 1'b0, 3'b111, 5'd3, 32'd100, 3'b001};
    tbl[6]  = '{1'b0, 1'b0, 3'b111, 5'd3, 32'd100, 3'b010};
    tbl[7]  = '{1'b0, 1'b0, 3'b111, 5'd3, 32'd100, 3'b100};
    tbl[8]  = '{1'b0, 1'b0, 3'b111, 5'd3, 32'd100, 3'b001};
    tbl[9]  = '{1'b0, 1'b0, 3'b111, 5'd3, 32'd100, 3'b010};
    tbl[10] = '{1'b0, 1'b0, 3'b111, 5'd3, 32'd100, 3'b100};
    tbl[11] = '{1'b0, 1'b1, 3'b101, 5'd3, 32'd100, 3'b000};
    tbl[12] = '{1'b0, 1'b1, 3'b101, 5'd3, 32'd100, 3'b000};
    tbl[13] = '{1'b0, 1'b1, 3'b101, 5'd3, 32'd100, 3'b000};
    tbl[14] = '{1'b0, 1'b0, 3'b101, 5'd3, 32'd100, 3'b001};
    tbl[15] = '{1'b0, 1'b0, 3'b101, 5'd3, 32'd100, 3'b100};
    tbl[16] = '{1'b0, 1'b0, 3'b000, 5'd3, 32'd100, 3'b000};
    tbl[17] = '{1'b1, 1'b0, 3'b000, 5'd3, 32'd100, 3'b000};
    tbl[18] = '{1'b0, 1'b0, 3'b001, 5'd0, 32'd99,  3'b001};
    tbl[19] = '{1'b0, 1'b0, 3'b011, 5'd0, 32'd99,  3'b010};
    tbl[20] = '{1'b0, 1'b0, 3'b000, 5'd3, 32'd100, 3'b000};
    tbl[21] = '{1'b0, 1'b0, 3'b010, 5'd3, 32'd100, 3'b010};
    tbl[22] = '{1'b1, 1'b0, 3'b111, 5'd3, 32'd100, 3'b000};
    tbl[23] = '{1'b0, 1'b0, 3'b111, 5'd3, 32'd100, 3'b001};
    tbl[24] = '{1'b0, 1'b0, 3'b000, 5'd3, 32'd100, 3'b000};

    a_req[1] = 5'd5; d_req[1] = 32'd1234;
    a_req[2] = 5'd7; d_req[2] = 32'h0000_0777;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_req[0]  = tbl[i].a0;
      d_req[0]  = tbl[i].d0;
      rst       = tbl[i].rst;
      hold      = tbl[i].hold;
      req_valid = tbl[i].valid;
      req_addr  = {a_req[2], a_req[1], a_req[0]};
      req_data  = {d_req[2], d_req[1], d_req[0]};

      // Expected write-stage contents after this cycle's edge.
      if (tbl[i].rst) begin
        cur = '{1'b0, 5'd0, 32'd0, 3'd0};
      end else if (tbl[i].ready != 3'b000) begin
        g = (tbl[i].ready == 3'b001) ? 0 : (tbl[i].ready == 3'b010) ? 1 : 2;
        cur.write = (a_req[g] != 5'd0);
        cur.addr  = a_req[g];
        cur.data  = d_req[g];
        cur.gid   = 3'(g);
      end else begin
        cur.write = 1'b0;
      end
      sb.push_back(cur);

      #1;
      chk("req_ready", i, 32'(req_ready), 32'(tbl[i].ready));

      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("write", i, 32'(write), 32'(got.write));
      chk("pending_mask", i, pending_mask, got.write ? (32'd1 << got.addr) : 32'd0);
      chk("writeaddress", i, 32'(writeaddress), 32'(got.addr));
      chk("dinreg", i, dinreg, got.data);
      chk("grant_id", i, 32'(grant_id), 32'(got.gid));
      if (i == 3) chk("rf_reg5", i, rf[5], 32'd1234);
    end

    // Starvation: after hold drops, every requester holding valid is served within N cycles.
    @(negedge clk);
    rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
    @(negedge clk);
    rst = 1'b0; hold = 1'b1;
    #1;
    chk("hold_ready", 100, 32'(req_ready), 32'd0);
    @(negedge clk);
    hold = 1'b0;
    seen = 3'b000;
    for (int c = 0; c < N; c++) begin
      #1;
      chk("onehot_ready", 101 + c, 32'($onehot(req_ready)), 32'd1);
      seen = seen | req_ready;
      @(negedge clk);
    end
    chk("starvation_seen", 104, 32'(seen), 32'b111);

    // Withdrawn request is never granted.
    req_valid = 3'b000;
    #1;
    chk("withdrawn_ready", 105, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("zero_reg_untouched", 106, 32'(zero_written), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
